if_id_stage: RTL and testbench
==============================

IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 The block SHALL have one clock, CLK, and one reset, reset; reset is synchronous and active-high, and all state changes occur on the rising edge of CLK.
REQ-002 Ports (name  direction  width  meaning):
- CLK  in  1  clock
- reset  in  1  synchronous active-high reset
- Stall  in  1  hold PC and IF/ID register (load-use bubble from hazard logic)
- Flush  in  1  squash the IF/ID register contents into a bubble
- PCSrc  in  1  branch taken; redirect fetch
- PCBranch  in  32  branch target
- in_Instr  in  32  instruction word read combinationally from instruction memory at PC
- PC  out  32  current fetch address to instruction memory
- Instr  out  32  latched instruction for the ID stage
- PCplus4  out  32  latched fetch address + 4 for the ID stage
- Valid  out  1  Instr holds a real fetched instruction
- Rs, Rt, Rd, shamt  out  5 each  fields of Instr [25:21], [20:16], [15:11], [10:6]
- Imm  out  16  Instr[15:0]
REQ-003 Rs, Rt, Rd, shamt and Imm SHALL be combinational slices of the registered Instr, so they carry no extra latency.

Function
REQ-004 The block SHALL hold two register groups: the PC register (PC) and the IF/ID register (Instr, PCplus4, Valid).
REQ-005 The fetch adder SHALL compute PC + 4 modulo 2^32; 32'hFFFFFFFC + 4 = 32'h00000000 with no overflow flag.
REQ-006 Each cycle, the PC update SHALL follow this priority:
- reset: PC = 0
- else PCSrc=1: PC = {PCBranch[31:2], 2'b00}
- else Stall=1: PC holds
- else: PC = PC + 4
REQ-007 Each cycle, the IF/ID update SHALL follow this priority:
- reset: Instr = 0, PCplus4 = 0, Valid = 0
- else PCSrc=1 or Flush=1: Instr = 0, PCplus4 = 0, Valid = 0 (bubble)
- else Stall=1: all fields hold
- else: Instr = in_Instr, PCplus4 = PC + 4, Valid = 1
REQ-008 Instruction word 0 SHALL be the canonical bubble (sll $0,$0,0); downstream control decode of Instr = 0 yields no register write and no memory write.
REQ-009 Latency SHALL be one cycle: an instruction presented on in_Instr in cycle N appears on Instr in cycle N+1, provided there is no stall, flush or redirect.
REQ-010 When PCSrc and Stall are both 1, the redirect SHALL win: PC loads the target and IF/ID becomes a bubble, because the stalled ID instruction is on the wrong path.
REQ-011 When Flush=1 and Stall=1 with PCSrc=0, the IF/ID register SHALL become a bubble and PC SHALL hold.
REQ-012 When Flush=1 alone, PC SHALL advance by 4 as normal.
REQ-013 Stall asserted for K consecutive cycles SHALL freeze PC and IF/ID for exactly K cycles; fetch resumes with the held PC on the first cycle Stall=0.
REQ-014 Redirect to the same address as the current PC SHALL still squash IF/ID for one cycle.
REQ-015 PCBranch[1:0] SHALL be ignored; there is no misaligned-address exception.
REQ-016 No output SHALL depend combinationally on Stall, Flush, PCSrc, PCBranch or in_Instr.

Reset
REQ-017 While reset=1 at a clock edge, the block SHALL set PC = 0, Instr = 0, PCplus4 = 0 and Valid = 0, regardless of Stall, Flush or PCSrc.
REQ-018 Reset asserted mid-stall or mid-redirect SHALL discard that pending operation; on the first edge with reset=0, the block fetches from address 0 and loads the instruction at 0 into IF/ID.
REQ-019 Before the first reset, output values are don't-care; the bench SHALL apply reset for at least one edge.

Verification
REQ-020 Sequential fetch: reset, then imem[0]=32'h20080005 and imem[4]=32'h20090003 -> after edge 1, PC=4, Instr=32'h20080005, PCplus4=4, Valid=1, Rt=8, Imm=5; after edge 2, PC=8, Instr=32'h20090003.
REQ-021 Stall: with PC=8, hold Stall=1 for 2 cycles -> PC stays 8 and Instr/PCplus4 stay unchanged for both edges; on the next unstalled edge, PC=12.
REQ-022 Redirect: PCSrc=1 and PCBranch=32'h00000043 with PC=12 -> PC=32'h40 and Instr=0, Valid=0 for one cycle; on the next edge, Instr = imem[0x40] and PCplus4=32'h44.
REQ-023 Simultaneous events: PCSrc=1 with Stall=1 -> redirect taken and bubble inserted; Flush=1 with Stall=1 -> bubble inserted and PC held; Flush=1 alone -> bubble inserted and PC+4.
REQ-024 Wrap and reset: redirect to 32'hFFFFFFFC -> next PC=0 and PCplus4=0; assert reset during a Stall=1 window -> PC=0 and Valid=0, then normal fetch from 0.

Source files
------------

// File: rtl/if_id_stage.sv
// if_id_stage: fetch PC register plus IF/ID pipeline register with stall, flush and redirect
module if_id_stage (
    input  logic        CLK,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        PCSrc,
    input  logic [31:0] PCBranch,
    input  logic [31:0] in_Instr,
    output logic [31:0] PC,
    output logic [31:0] Instr,
    output logic [31:0] PCplus4,
    output logic        Valid,
    output logic [4:0]  Rs,
    output logic [4:0]  Rt,
    output logic [4:0]  Rd,
    output logic [4:0]  shamt,
    output logic [15:0] Imm
);
    logic [31:0] pc_plus4;

    assign pc_plus4 = PC + 32'd4;
    assign Rs       = Instr[25:21];
    assign Rt       = Instr[20:16];
    assign Rd       = Instr[15:11];
    assign shamt    = Instr[10:6];
    assign Imm      = Instr[15:0];

    // PC: redirect beats stall; branch target low bits are dropped to keep word alignment
    always_ff @(posedge CLK) begin
        if (reset)
            PC <= 32'd0;
        else if (PCSrc)
            PC <= {PCBranch[31:2], 2'b00};
        else if (!Stall)
            PC <= pc_plus4;
    end

    // IF/ID: a redirect or flush squashes to the all-zero bubble even while stalled
    always_ff @(posedge CLK) begin
        if (reset || PCSrc || Flush) begin
            Instr   <= 32'd0;
            PCplus4 <= 32'd0;
            Valid   <= 1'b0;
        end else if (!Stall) begin
            Instr   <= in_Instr;
            PCplus4 <= pc_plus4;
            Valid   <= 1'b1;
        end
    end
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: randomized and directed check of if_id_stage against a behavioural fetch model
module tb_if_id_stage;
    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        Stall = 1'b0;
    logic        Flush = 1'b0;
    logic        PCSrc = 1'b0;
    logic [31:0] PCBranch = 32'd0;
    logic [31:0] in_Instr;
    logic [31:0] PC, Instr, PCplus4;
    logic        Valid;
    logic [4:0]  Rs, Rt, Rd, shamt;
    logic [15:0] Imm;

    logic [31:0] salt = 32'd0;
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid;
    int          total = 0;
    int          bad = 0;

    if_id_stage dut (
        .CLK(CLK), .reset(reset), .Stall(Stall), .Flush(Flush), .PCSrc(PCSrc),
        .PCBranch(PCBranch), .in_Instr(in_Instr), .PC(PC), .Instr(Instr),
        .PCplus4(PCplus4), .Valid(Valid), .Rs(Rs), .Rt(Rt), .Rd(Rd),
        .shamt(shamt), .Imm(Imm)
    );

    always #5 CLK = ~CLK;

    // instruction memory contents as a pure function of the word address
    function automatic logic [31:0] word(input logic [31:0] a, input logic [31:0] s);
        if (a == 32'd0) return 32'h20080005;
        if (a == 32'd4) return 32'h20090003;
        return (a * 32'h9E3779B1) ^ s ^ 32'h5A5A1234;
    endfunction

    assign in_Instr = word(PC, salt);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("pc", PC, m_pc);
        chk("instr", Instr, m_instr);
        chk("pcplus4", PCplus4, m_pc4);
        chk("valid", {31'd0, Valid}, {31'd0, m_valid});
        chk("rs", {27'd0, Rs}, {27'd0, m_instr[25:21]});
        chk("rt", {27'd0, Rt}, {27'd0, m_instr[20:16]});
        chk("rd", {27'd0, Rd}, {27'd0, m_instr[15:11]});
        chk("shamt", {27'd0, shamt}, {27'd0, m_instr[10:6]});
        chk("imm", {16'd0, Imm}, {16'd0, m_instr[15:0]});
    endtask

    // apply one cycle of controls, advance the model, then compare after the edge
    task automatic cycle(input logic r, input logic s, input logic f, input logic p, input logic [31:0] b);
        logic [31:0] fetched;
        fetched  = word(m_pc, salt);
        reset    = r;
        Stall    = s;
        Flush    = f;
        PCSrc    = p;
        PCBranch = b;
        if (r) begin
            m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0;
        end else begin
            if (p || f) begin
                m_instr = 0; m_pc4 = 0; m_valid = 0;
            end else if (!s) begin
                m_instr = fetched; m_pc4 = m_pc + 4; m_valid = 1;
            end
            if (p) m_pc = b & ~32'd3;
            else if (!s) m_pc = m_pc + 4;
        end
        @(posedge CLK);
        #1;
        check_all();
    endtask

    initial begin
        salt = $urandom;
        m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0;
        cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 1, 1, 32'h1234);
        chk("reset_pc", PC, 32'd0);
        cycle(0, 0, 0, 0, 0);
        chk("seq1_pc", PC, 32'd4);
        chk("seq1_instr", Instr, 32'h20080005);
        chk("seq1_rt", {27'd0, Rt}, 32'd8);
        chk("seq1_imm", {16'd0, Imm}, 32'd5);
        cycle(0, 0, 0, 0, 0);
        chk("seq2_instr", Instr, 32'h20090003);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        chk("stall_pc", PC, 32'd8);
        cycle(0, 0, 0, 0, 0);
        chk("unstall_pc", PC, 32'd12);
        cycle(0, 0, 0, 1, 32'h43);
        chk("redir_pc", PC, 32'h40);
        chk("redir_valid", {31'd0, Valid}, 32'd0);
        cycle(0, 0, 0, 0, 0);
        chk("redir_pc4", PCplus4, 32'h44);
        cycle(0, 1, 0, 1, 32'h100);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, m_pc);
        cycle(0, 0, 0, 1, 32'hFFFFFFFF);
        cycle(0, 0, 0, 0, 0);
        chk("wrap_pc", PC, 32'd0);
        chk("wrap_pc4", PCplus4, 32'd0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        chk("rst_stall_instr", Instr, 32'h20080005);
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 6) == 0,
                  ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
